// File: rtl/unified_memory_pkg.sv
// Shared types and elaboration helpers for the unified instruction/data memory.
package unified_memory_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_t;

    function automatic int data_seg_size(input int depth, input int data_base);
        return depth - data_base;
    endfunction

    function automatic bit params_legal(input int addr_w, input int depth, input int data_base);
        return (addr_w > 0) && (addr_w < 31) && (depth > 1) &&
               (depth <= (1 << addr_w)) && (data_base >= 0) && (data_base < depth);
    endfunction

endpackage

// File: rtl/memory_init_ctrl.sv
// Post-reset clear sequencer: walks every word once, then parks in READY until reset.
module memory_init_ctrl
    import unified_memory_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int IDX_W          = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             busy,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_addr
);

    // state | meaning
    // CLEAR | zeroing Mem[cnt] each cycle, all requests dropped
    // READY | normal operation, held until the next reset
    localparam init_state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    init_state_t      state;
    init_state_t      next_state;
    logic [IDX_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt == LAST_IDX) begin
                    next_state = READY;
                end
            end
            READY: next_state = READY;
            default: next_state = RST_STATE;
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/unified_memory.sv
// Shared instruction/data memory: I fetch port plus D load/store port into one array,
// with data-segment offset and bounds faulting, write-first bypass and post-reset clear.
module unified_memory
    import unified_memory_pkg::*;
#(
    parameter int WORD_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int DATA_BASE      = 128,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_fault,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SEG_SIZE = (ADDR_W + 1)'(data_seg_size(DEPTH, DATA_BASE));
    localparam logic [ADDR_W:0] BASE_W   = (ADDR_W + 1)'(DATA_BASE);
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);

    if (!params_legal(ADDR_W, DEPTH, DATA_BASE)) begin : g_param_err
        $error("unified_memory: need DEPTH <= 2**ADDR_W and DATA_BASE < DEPTH");
    end

    logic [WORD_W-1:0] mem [DEPTH];

    logic             clr_we;
    logic [IDX_W-1:0] clr_addr;

    memory_init_ctrl #(
        .DEPTH          (DEPTH),
        .IDX_W          (IDX_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic              i_acc;
    logic              d_acc;
    logic [ADDR_W:0]   pa;
    logic [IDX_W-1:0]  pa_idx;
    logic [IDX_W-1:0]  i_idx;
    logic              d_oob;
    logic              d_wr;
    logic              i_oob;
    logic [WORD_W-1:0] i_rdata_next;
    logic [WORD_W-1:0] d_rdata_next;

    assign i_acc  = i_req & ~busy;
    assign d_acc  = d_req & ~busy;
    assign pa     = BASE_W + {1'b0, d_addr};
    assign pa_idx = pa[IDX_W-1:0];
    assign i_idx  = i_addr[IDX_W-1:0];
    assign d_oob  = ({1'b0, d_addr} >= SEG_SIZE);
    assign d_wr   = d_acc & d_we & ~d_oob;
    assign i_oob  = ({1'b0, i_addr} >= DEPTH_W);

    // Write-first: a same-cycle store to the fetched word is forwarded to the I port.
    always_comb begin
        i_rdata_next = mem[i_idx];
        if (i_oob) begin
            i_rdata_next = '0;
        end else if (d_wr && (pa == {1'b0, i_addr})) begin
            i_rdata_next = d_wdata;
        end
    end

    always_comb begin
        d_rdata_next = mem[pa_idx];
        if (d_oob) begin
            d_rdata_next = '0;
        end else if (d_we) begin
            d_rdata_next = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (d_wr) begin
            mem[pa_idx] <= d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_valid <= 1'b0;
            i_rdata <= '0;
            d_valid <= 1'b0;
            d_rdata <= '0;
            d_fault <= 1'b0;
        end else begin
            i_valid <= i_acc;
            d_valid <= d_acc;
            d_fault <= d_acc & d_oob;
            if (i_acc) begin
                i_rdata <= i_rdata_next;
            end
            if (d_acc) begin
                d_rdata <= d_rdata_next;
            end
        end
    end

endmodule
